rom_sdram_writer: RTL
=====================

Name: rom_sdram_writer

Overview:
- Sits directly downstream of the ROM loader address decoder.
- Consumes its one-cycle SDRAM-region write strobes (68k, tiles, sprites), the word address and the 16-bit download data.
- Buffers them in a small FIFO and issues them to the SDRAM controller's write port over a req/ack handshake.
- Back-pressures the HPS download via ioctl_wait, and reports completion and overflow to the top level.

Parameters:
- DEPTH, 4: FIFO entries; power of two, minimum 4.
- WAIT_LVL, DEPTH-2: occupancy at or above which ioctl_wait asserts.

Ports:
- clk_sys  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- load_en  in  1  download in progress; used to detect the end of a download.
- rom_68k_we  in  1  one-cycle write strobe, 68k region.
- rom_tiles_we  in  1  one-cycle write strobe, tiles region.
- rom_sprites_we  in  1  one-cycle write strobe, sprites region.
- rom_addr  in  26  word address; bit 25 is always 0 for SDRAM regions.
- rom_data  in  16  write data, valid in the same cycle as the strobe.
- ioctl_wait  out  1  back-pressure to the HPS download engine.
- sdr_req  out  1  write request to the SDRAM controller.
- sdr_ack  in  1  one-cycle accept pulse from the controller.
- sdr_addr  out  25  SDRAM word address.
- sdr_data  out  16  SDRAM write data.
- load_done  out  1  one-cycle pulse when a download has fully drained.
- overflow  out  1  sticky flag: a write was dropped because the FIFO was full.

Behaviour:
- Reset values: all outputs 0, FIFO empty, wr_ptr = rd_ptr = 0, count = 0, FSM in IDLE.
- Push:
  - push = rom_68k_we | rom_tiles_we | rom_sprites_we.
  - Entry stored = {rom_addr[24:0], rom_data}.
  - Other strobes (Z80, 007232, prom) are not ports of this block; the loader routes them to BRAM.
- Full and overflow:
  - Push with count == DEPTH and no pop in the same cycle: entry is dropped and overflow is set.
  - overflow is cleared only by reset.
- Simultaneous push and pop: count is unchanged. A push into a full FIFO is accepted if a pop occurs in the same cycle.
- Pointers: log2(DEPTH) bits each and wrap naturally. count is log2(DEPTH)+1 bits.
- ioctl_wait is registered: ioctl_wait <= (next_count >= WAIT_LVL). The margin absorbs the 2-cycle strobe pipeline between ioctl_wr and the push.
- FSM, states IDLE and REQ:
  - IDLE: if count != 0, load the head entry into sdr_addr/sdr_data, set sdr_req = 1, go to REQ. First request is 1 cycle after the push into an empty FIFO.
  - REQ: hold sdr_req, sdr_addr and sdr_data stable until sdr_ack. On sdr_ack, pop the entry.
    - If the FIFO still holds another entry (count > 1 before the pop): load the next head and stay in REQ, sdr_req stays high. Back-to-back throughput is 1 write per ack.
    - Otherwise: clear sdr_req and go to IDLE.
  - sdr_ack while in IDLE is ignored.
- load_done:
  - load_en_d is load_en delayed one cycle.
  - pending is set on a falling edge of load_en (load_en_d & ~load_en).
  - While pending, count == 0 and state == IDLE: pulse load_done for 1 cycle and clear pending.
  - A rising edge of load_en while pending clears pending with no pulse.
- Reset mid-transfer: sdr_req drops in the same cycle reset is sampled and the FIFO contents are discarded. The SDRAM controller must tolerate an abandoned request.
- No combinational path from any input to any output.

Decomposition:
- Shared package rom_load_pkg holds:
  - region byte lengths and SDRAM byte offsets (68k 0x0000000, tiles 0x1000000, sprites 0x1200000);
  - SDR_AW = 25;
  - fifo entry typedef {addr[24:0], data[15:0]}.
- One sub-module, sync_fifo_41: parameterised synchronous FIFO providing push/pop/count/full/empty, instantiated with DEPTH. The FSM and handshake stay in the top module.

Test Plan:
- Single write: rom_68k_we with rom_addr=0x000123, rom_data=0xBEEF; sdr_ack 3 cycles after req -> sdr_req rises 1 cycle after the strobe, sdr_addr=0x000123, sdr_data=0xBEEF held until ack, then req drops.
- Burst: 6 sprite strobes on consecutive cycles from word 0x900000, ack held low for 10 cycles, then ack every cycle -> ioctl_wait asserts when count reaches 2. With DEPTH=4 the 5th and 6th strobes overflow; overflow=1 and exactly 4 writes are issued (0x900000..0x900003) in order.
- Simultaneous push/pop: count=1, strobe and ack in the same cycle -> count stays 1, req stays high, next head is presented the following cycle.
- Pointer wrap: 20 writes with an ack 2 cycles after each req -> all 20 addresses and data emerge in order, no overflow, ioctl_wait never asserts.
- load_done: drop load_en while 2 entries are pending -> load_done pulses exactly once, 1 cycle after the second ack's pop leaves the FSM in IDLE. A rising edge of load_en before the drain completes gives no pulse.
- Reset mid-REQ: assert reset while sdr_req=1 with 3 entries queued -> next cycle all outputs are 0 and count=0. A later ack is ignored and no write is reissued.

Source files
------------

// File: rtl/rom_load_pkg.sv
// Shared ROM-loader definitions: SDRAM region map, address width and the
// write-FIFO entry layout.
package rom_load_pkg;

  localparam int unsigned SDR_AW = 25;
  localparam int unsigned DATA_W = 16;

  // Region byte lengths and byte offsets inside SDRAM
  localparam int unsigned ROM_68K_LEN     = 32'h0100000;
  localparam int unsigned ROM_TILES_LEN   = 32'h0200000;
  localparam int unsigned ROM_SPRITES_LEN = 32'h0200000;
  localparam int unsigned ROM_68K_OFS     = 32'h0000000;
  localparam int unsigned ROM_TILES_OFS   = 32'h1000000;
  localparam int unsigned ROM_SPRITES_OFS = 32'h1200000;

  typedef struct packed {
    logic [SDR_AW-1:0] addr;
    logic [DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/rom_sdram_writer_if.sv
// SDRAM controller write port: request/ack handshake with address and data.
interface rom_sdram_writer_if;
  import rom_load_pkg::*;

  logic              sdr_req;
  logic              sdr_ack;
  logic [SDR_AW-1:0] sdr_addr;
  logic [DATA_W-1:0] sdr_data;

  modport master (output sdr_req, output sdr_addr, output sdr_data, input sdr_ack);
  modport slave  (input sdr_req, input sdr_addr, input sdr_data, output sdr_ack);
endinterface

// File: rtl/sync_fifo_41.sv
// Synchronous FIFO with registered pointers/count; exposes the head and the
// entry behind it so the writer can chain requests without a bubble.
module sync_fifo_41
  import rom_load_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  fifo_entry_t            din,
  output fifo_entry_t            head_c,
  output fifo_entry_t            head_next_c,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full_c,
  output logic                   empty_c
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fifo_entry_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             wr_en, rd_en;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  // A full FIFO still accepts a write when a read frees a slot in the same cycle
  assign rd_en   = pop && !empty_c;
  assign wr_en   = push && (!full_c || rd_en);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(wr_en) - CNT_W'(rd_en);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

  assign head_c      = mem_q[rd_ptr_q];
  assign head_next_c = mem_q[rd_ptr_q + PTR_W'(1)];
  assign count       = count_q;

endmodule

// File: rtl/rom_sdram_writer.sv
// Buffers ROM-loader SDRAM writes and issues them over a req/ack port,
// with download back-pressure, end-of-download pulse and overflow flag.
module rom_sdram_writer
  import rom_load_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned WAIT_LVL = DEPTH - 2
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    load_en,
  input  logic                    rom_68k_we,
  input  logic                    rom_tiles_we,
  input  logic                    rom_sprites_we,
  input  logic [SDR_AW:0]         rom_addr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic                    ioctl_wait,
  rom_sdram_writer_if.master      sdr,
  output logic                    load_done,
  output logic                    overflow
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic {IDLE, REQ} state_t;

  state_t           state_q, state_d;
  logic             sdr_req_q, sdr_req_d;
  fifo_entry_t      out_q, out_d;
  logic             ioctl_wait_q, ioctl_wait_d;
  logic             overflow_q, overflow_d;
  logic             load_done_q, load_done_d;
  logic             load_en_d_q;
  logic             pending_q, pending_d;

  fifo_entry_t      push_entry, head_c, head_next_c;
  logic [CNT_W-1:0] count, next_count;
  logic             push, pop, accept, full_c, empty_c;
  logic             load_rise, load_fall, drained;
  logic             unused_addr_msb;

  assign unused_addr_msb = rom_addr[SDR_AW];

  assign push       = rom_68k_we | rom_tiles_we | rom_sprites_we;
  assign push_entry = '{addr: rom_addr[SDR_AW-1:0], data: rom_data};
  assign pop        = (state_q == REQ) && sdr.sdr_ack;
  assign accept     = push && (!full_c || pop);
  assign next_count = count + CNT_W'(accept) - CNT_W'(pop);

  sync_fifo_41 #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk_sys),
    .reset      (reset),
    .push       (accept),
    .pop        (pop),
    .din        (push_entry),
    .head_c     (head_c),
    .head_next_c(head_next_c),
    .count      (count),
    .full_c     (full_c),
    .empty_c    (empty_c)
  );

  // Request FSM: on ack, chain straight to the next entry if one remains
  always_comb begin
    state_d   = state_q;
    sdr_req_d = sdr_req_q;
    out_d     = out_q;
    unique case (state_q)
      IDLE: begin
        if (!empty_c) begin
          out_d     = head_c;
          sdr_req_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (sdr.sdr_ack) begin
          if (count > CNT_W'(1)) begin
            out_d = head_next_c;
          end else if (accept) begin
            out_d = push_entry;
          end else begin
            sdr_req_d = 1'b0;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Status: back-pressure, sticky overflow and end-of-download detection
  always_comb begin
    load_rise    = load_en && !load_en_d_q;
    load_fall    = !load_en && load_en_d_q;
    drained      = pending_q && (count == '0) && (state_q == IDLE);
    ioctl_wait_d = (next_count >= CNT_W'(WAIT_LVL));
    overflow_d   = overflow_q || (push && !accept);
    load_done_d  = drained && !load_rise;
    pending_d    = pending_q;
    if (load_fall) pending_d = 1'b1;
    if (drained || load_rise) pending_d = 1'b0;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q      <= IDLE;
      sdr_req_q    <= 1'b0;
      out_q        <= '0;
      ioctl_wait_q <= 1'b0;
      overflow_q   <= 1'b0;
      load_done_q  <= 1'b0;
      load_en_d_q  <= 1'b0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sdr_req_q    <= sdr_req_d;
      out_q        <= out_d;
      ioctl_wait_q <= ioctl_wait_d;
      overflow_q   <= overflow_d;
      load_done_q  <= load_done_d;
      load_en_d_q  <= load_en;
      pending_q    <= pending_d;
    end
  end

  assign sdr.sdr_req  = sdr_req_q;
  assign sdr.sdr_addr = out_q.addr;
  assign sdr.sdr_data = out_q.data;
  assign ioctl_wait   = ioctl_wait_q;
  assign overflow     = overflow_q;
  assign load_done    = load_done_q;

endmodule
